// File: rtl/s2m_fifo_pkg.sv
// Shared constants for the multi-channel stream-to-MM FIFO bridge.
package s2m_fifo_pkg;

  localparam logic [31:0] EMPTY_WORD = 32'hDEAD_0000;

  // Status flag positions, counted down from the readdata MSB
  localparam int unsigned STAT_EMPTY_FROM_MSB = 0;
  localparam int unsigned STAT_FULL_FROM_MSB  = 1;

  typedef enum logic {
    ADDR_DATA   = 1'b0,
    ADDR_STATUS = 1'b1
  } addr_sel_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s2m_fifo_chan.sv
// One FIFO channel: simple-dual-port RAM with asynchronous read port,
// wrapping pointers and an explicit 0..DEPTH level counter.
module s2m_fifo_chan #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [LW-1:0]     level,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/s2m_fifo_mc.sv
// Multi-channel Avalon-ST sink to Avalon-MM read-slave FIFO bridge.
// Optional level interrupt enabled by defining S2M_FIFO_MC_IRQ_EN.
module s2m_fifo_mc
  import s2m_fifo_pkg::*;
#(
  parameter int unsigned  DATA_W     = 32,
  parameter int unsigned  DEPTH      = 64,
  parameter int unsigned  N_CH       = 2,
  parameter int unsigned  EMPTY_MODE = 0,
  parameter int unsigned  IRQ_LEVEL  = 48,
  localparam int unsigned CH_W       = ch_width(N_CH),
  localparam int unsigned LW         = $clog2(DEPTH) + 1
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic [DATA_W-1:0] avalonst_sink_data,
  input  logic [CH_W-1:0]   avalonst_sink_channel,
  input  logic              avalonst_sink_valid,
  output logic              avalonst_sink_ready,
  input  logic [CH_W:0]     avalonmm_read_slave_address,
  input  logic              avalonmm_read_slave_read,
  output logic [DATA_W-1:0] avalonmm_read_slave_readdata,
  output logic              avalonmm_read_slave_waitrequest,
  output logic              avalonmm_read_slave_readdatavalid
`ifdef S2M_FIFO_MC_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [DATA_W-1:0] EMPTY_W = DATA_W'(EMPTY_WORD);

  logic [DATA_W-1:0] ch_rdata [N_CH];
  logic [LW-1:0]     ch_level [N_CH];
  logic [N_CH-1:0]   ch_empty;
  logic [N_CH-1:0]   ch_full;
  logic [N_CH-1:0]   ch_push;
  logic [N_CH-1:0]   ch_pop;

  logic              sink_full;
  addr_sel_e         rd_sel;
  logic [CH_W-1:0]   rd_ch;
  logic              sel_hit;
  logic              sel_empty;
  logic              sel_full;
  logic [LW-1:0]     sel_level;
  logic [DATA_W-1:0] sel_rdata;
  logic              stall;
  logic              accept;
  logic [DATA_W-1:0] rd_word;

  // Channels outside 0..N_CH-1 never match, so they look non-full and drop
  always_comb begin
    sink_full = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (avalonst_sink_channel == CH_W'(i)) sink_full = ch_full[i];
    end
  end

  assign avalonst_sink_ready = ~reset & ~sink_full;

  assign rd_sel = addr_sel_e'(avalonmm_read_slave_address[0]);
  assign rd_ch  = avalonmm_read_slave_address[CH_W:1];

  always_comb begin
    sel_hit   = 1'b0;
    sel_empty = 1'b0;
    sel_full  = 1'b0;
    sel_level = '0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        sel_hit   = 1'b1;
        sel_empty = ch_empty[i];
        sel_full  = ch_full[i];
        sel_level = ch_level[i];
        sel_rdata = ch_rdata[i];
      end
    end
  end

  assign stall  = avalonmm_read_slave_read & (rd_sel == ADDR_DATA) & sel_hit &
                  sel_empty & (EMPTY_MODE == 0);
  assign accept = avalonmm_read_slave_read & ~stall & ~reset;
  assign avalonmm_read_slave_waitrequest = stall;

  always_comb begin
    rd_word = '0;
    if (rd_sel == ADDR_STATUS) begin
      rd_word[DATA_W-1-STAT_EMPTY_FROM_MSB] = sel_empty;
      rd_word[DATA_W-1-STAT_FULL_FROM_MSB]  = sel_full;
      rd_word[LW-1:0]                       = sel_level;
    end else if (sel_hit) begin
      rd_word = sel_empty ? EMPTY_W : sel_rdata;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    assign ch_push[g] = avalonst_sink_valid & avalonst_sink_ready &
                        (avalonst_sink_channel == CH_W'(g));
    assign ch_pop[g]  = accept & (rd_sel == ADDR_DATA) & (rd_ch == CH_W'(g)) &
                        ~ch_empty[g];

    s2m_fifo_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk   (wrclock),
      .reset (reset),
      .push  (ch_push[g]),
      .wdata (avalonst_sink_data),
      .pop   (ch_pop[g]),
      .rdata (ch_rdata[g]),
      .level (ch_level[g]),
      .empty (ch_empty[g]),
      .full  (ch_full[g])
    );
  end

  always_ff @(posedge wrclock) begin
    if (reset) begin
      avalonmm_read_slave_readdatavalid <= 1'b0;
      avalonmm_read_slave_readdata      <= '0;
    end else begin
      avalonmm_read_slave_readdatavalid <= accept;
      if (accept) avalonmm_read_slave_readdata <= rd_word;
    end
  end

`ifdef S2M_FIFO_MC_IRQ_EN
  localparam logic [LW-1:0] IRQ_THR = LW'(IRQ_LEVEL);

  logic irq_any;

  always_comb begin
    irq_any = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_level[i] >= IRQ_THR) irq_any = 1'b1;
    end
  end

  always_ff @(posedge wrclock) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_any;
  end
`endif

endmodule

// File: tb/tb_s2m_fifo_mc.sv
// Scoreboard bench for s2m_fifo_mc: one instance per empty-read mode,
// expected read words queued at issue and checked by a monitor on readdatavalid.
module tb_s2m_fifo_mc;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] d0 = '0, rdata0, d1 = '0, rdata1;
  logic        c0 = 1'b0, v0 = 1'b0, rdy0, r0 = 1'b0, w0, rdv0;
  logic        c1 = 1'b0, v1 = 1'b0, rdy1, r1 = 1'b0, w1, rdv1;
  logic [1:0]  a0 = '0, a1 = '0;
`ifdef S2M_FIFO_MC_IRQ_EN
  logic        irq0, irq1;
`endif

  s2m_fifo_mc #(.DATA_W(32), .DEPTH(64), .N_CH(2), .EMPTY_MODE(0), .IRQ_LEVEL(48)) dut0 (
    .wrclock                           (clk),
    .reset                             (reset),
    .avalonst_sink_data                (d0),
    .avalonst_sink_channel             (c0),
    .avalonst_sink_valid               (v0),
    .avalonst_sink_ready               (rdy0),
    .avalonmm_read_slave_address       (a0),
    .avalonmm_read_slave_read          (r0),
    .avalonmm_read_slave_readdata      (rdata0),
    .avalonmm_read_slave_waitrequest   (w0),
    .avalonmm_read_slave_readdatavalid (rdv0)
`ifdef S2M_FIFO_MC_IRQ_EN
    ,
    .irq                               (irq0)
`endif
  );

  s2m_fifo_mc #(.DATA_W(32), .DEPTH(64), .N_CH(2), .EMPTY_MODE(1), .IRQ_LEVEL(48)) dut1 (
    .wrclock                           (clk),
    .reset                             (reset),
    .avalonst_sink_data                (d1),
    .avalonst_sink_channel             (c1),
    .avalonst_sink_valid               (v1),
    .avalonst_sink_ready               (rdy1),
    .avalonmm_read_slave_address       (a1),
    .avalonmm_read_slave_read          (r1),
    .avalonmm_read_slave_readdata      (rdata1),
    .avalonmm_read_slave_waitrequest   (w1),
    .avalonmm_read_slave_readdatavalid (rdv1)
`ifdef S2M_FIFO_MC_IRQ_EN
    ,
    .irq                               (irq1)
`endif
  );

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", n, cyc, act, exp);
    end
  endtask

  task automatic mon();
    forever begin
      @(negedge clk);
      if (rdv0) begin
        if (q0.size() == 0) chk("rdv0_unexpected", rdv0, 0);
        else begin
          exp_t e = q0.pop_front();
          chk("rd0_data", rdata0, e.d);
          chk("rd0_latency", cyc, e.c);
        end
      end
      if (rdv1) begin
        if (q1.size() == 0) chk("rdv1_unexpected", rdv1, 0);
        else begin
          exp_t e = q1.pop_front();
          chk("rd1_data", rdata1, e.d);
          chk("rd1_latency", cyc, e.c);
        end
      end
    end
  endtask

  // Called at a negedge; leaves read asserted so reads can run back to back
  task automatic rd0(input logic [1:0] addr, input logic [31:0] exp);
    int n = 0;
    a0 = addr;
    r0 = 1'b1;
    #1;
    while (w0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (w0) chk("rd0_timeout", w0, 0);
    else    q0.push_back('{exp, cyc + 1});
    @(negedge clk);
  endtask

  task automatic push0(input logic ch, input logic [31:0] d);
    c0 = ch;
    d0 = d;
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      mon();
    join_none

    repeat (2) @(negedge clk);
    #1;
    chk("ready_in_reset", rdy0, 0);
    chk("rdv_after_reset", rdv0, 0);
    chk("rdata_after_reset", rdata0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", rdy0, 1);
    @(negedge clk);

    push0(0, 32'h1);
    push0(0, 32'h2);
    push0(0, 32'h3);
    rd0(2'b00, 32'h1);
    rd0(2'b00, 32'h2);
    rd0(2'b00, 32'h3);
    rd0(2'b01, 32'h8000_0000);
    r0 = 1'b0;

    for (int i = 0; i < 64; i++) push0(1, 32'h100 + i);
    c0 = 1'b1;
    #1;
    chk("ready_ch1_full", rdy0, 0);
    c0 = 1'b0;
    #1;
    chk("ready_ch0_free", rdy0, 1);
    @(negedge clk);
    rd0(2'b11, 32'h4000_0040);
    // Pop from the full channel while offering a word: no bypass, word dropped
    c0 = 1'b1; d0 = 32'hBAD; v0 = 1'b1; a0 = 2'b10; r0 = 1'b1;
    #1;
    chk("ready_full_pop", rdy0, 0);
    chk("wait_full_pop", w0, 0);
    q0.push_back('{32'h100, cyc + 1});
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 1; i < 64; i++) rd0(2'b10, 32'h100 + i);
    rd0(2'b11, 32'h8000_0000);
    r0 = 1'b0;

    a0 = 2'b00;
    r0 = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_wait", w0, 1);
      @(negedge clk);
    end
    c0 = 1'b0; d0 = 32'hAB; v0 = 1'b1;
    #1;
    chk("stall_push_cycle", w0, 1);
    @(negedge clk);
    v0 = 1'b0;
    #1;
    chk("stall_release", w0, 0);
    q0.push_back('{32'hAB, cyc + 1});
    @(negedge clk);
    r0 = 1'b0;

    for (int i = 0; i < 5; i++) push0(0, 32'h1000 + i);
    for (int i = 0; i < 200; i++) begin
      c0 = 1'b0; d0 = 32'h1005 + i; v0 = 1'b1; a0 = 2'b00; r0 = 1'b1;
      #1;
      chk("stream_wait", w0, 0);
      chk("stream_ready", rdy0, 1);
      q0.push_back('{32'h1000 + i, cyc + 1});
      @(negedge clk);
    end
    v0 = 1'b0;
    rd0(2'b01, 32'h0000_0005);
    r0 = 1'b0;

    // Read accepted in the same cycle reset is sampled: no readdatavalid
    a0 = 2'b00; r0 = 1'b1; reset = 1'b1;
    @(negedge clk);
    r0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd0(2'b01, 32'h8000_0000);
    r0 = 1'b0;

    a1 = 2'b00; r1 = 1'b1;
    #1;
    chk("mode1_empty_wait", w1, 0);
    q1.push_back('{32'hDEAD_0000, cyc + 1});
    @(negedge clk);
    a1 = 2'b01;
    #1;
    q1.push_back('{32'h8000_0000, cyc + 1});
    @(negedge clk);
    r1 = 1'b0; c1 = 1'b0; d1 = 32'h55; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; a1 = 2'b00; r1 = 1'b1;
    #1;
    chk("mode1_data_wait", w1, 0);
    q1.push_back('{32'h55, cyc + 1});
    @(negedge clk);
    a1 = 2'b01;
    q1.push_back('{32'h8000_0000, cyc + 1});
    @(negedge clk);
    r1 = 1'b0;

`ifdef S2M_FIFO_MC_IRQ_EN
    for (int i = 0; i < 47; i++) push0(1, i);
    chk("irq_below", irq0, 0);
    push0(1, 47);
    chk("irq_registered", irq0, 0);
    @(negedge clk);
    chk("irq_set", irq0, 1);
    rd0(2'b10, 32'h0);
    r0 = 1'b0;
    chk("irq_hold", irq0, 1);
    @(negedge clk);
    chk("irq_clear", irq0, 0);
    for (int i = 1; i < 48; i++) rd0(2'b10, i);
    r0 = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
